// File: rtl/control_path_p_if.sv
// Handshake bundle between the S/Y machine controller and its environment:
// mode/strobe/flag requests in, regime status and datapath controls out.
interface control_path_p_if #(
    parameter int STEP_W = 2,
    parameter int PH_W   = 2
);
    logic [1:0]        on;
    logic              start;
    logic              abort;
    logic              s_last;
    logic [1:0]        regime;
    logic              active;
    logic              done;
    logic [PH_W-1:0]   phase;
    logic [1:0]        y_select_next;
    logic [STEP_W-1:0] s_step;
    logic              y_en;
    logic              s_en;
    logic              y_store_x;
    logic              s_add;
    logic              s_zero;

    modport master (
        output on, start, abort, s_last,
        input  regime, active, done, phase, y_select_next, s_step,
               y_en, s_en, y_store_x, s_add, s_zero
    );

    modport slave (
        input  on, start, abort, s_last,
        output regime, active, done, phase, y_select_next, s_step,
               y_en, s_en, y_store_x, s_add, s_zero
    );
endinterface

// File: rtl/control_path_p.sv
// Four-regime S/Y machine controller: idle, enumerate, manual step, update.
// Regime/active/phase/done are registered; datapath controls are decoded per cycle.
module control_path_p #(
    parameter int STEP_W      = 2,
    parameter int PH_W        = 2,
    parameter int ENUM_PHASES = 4,
    parameter int ENUM_STEP   = 2,
    parameter int DEC_STEP    = 1,
    parameter int UPD_STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    control_path_p_if.slave  bus
);
    typedef enum logic [1:0] {R0 = 2'd0, R1 = 2'd1, R2 = 2'd2, R3 = 2'd3} regime_t;

    typedef struct packed {
        logic [1:0]        ysel;
        logic [STEP_W-1:0] step;
        logic              yen;
        logic              sen;
        logic              ysx;
        logic              sadd;
        logic              szero;
    } ctl_t;

    localparam logic [PH_W-1:0]   PH_INIT = PH_W'(ENUM_PHASES - 1);
    localparam logic [PH_W-1:0]   PH_UPD  = PH_W'(3);
    localparam logic [STEP_W-1:0] ENUM_S  = STEP_W'(ENUM_STEP);
    localparam logic [STEP_W-1:0] DEC_S   = STEP_W'(DEC_STEP);
    localparam logic [STEP_W-1:0] UPD_S   = STEP_W'(UPD_STEP);

    regime_t         rg_q, rg_d;
    logic            act_q, act_d;
    logic            done_q, done_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [1:0]      upd_ph;
    ctl_t            ctl;

    // The update sequence only looks at the low two phase bits.
    assign upd_ph = 2'(ph_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rg_q   <= R0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            ph_q   <= PH_INIT;
        end else begin
            rg_q   <= rg_d;
            act_q  <= act_d;
            done_q <= done_d;
            ph_q   <= ph_d;
        end
    end

    always_comb begin
        rg_d   = rg_q;
        act_d  = act_q;
        ph_d   = ph_q;
        done_d = 1'b0;
        ctl    = '0;
        if (bus.abort) begin
            // Cancel beats every other condition, including the final write.
            rg_d  = R0;
            act_d = 1'b0;
            ph_d  = PH_INIT;
        end else begin
            case (rg_q)
                R0: begin
                    rg_d = regime_t'(bus.on);
                    ph_d = (bus.on == 2'd3) ? PH_UPD : PH_INIT;
                end
                R1: begin
                    if (!act_q) begin
                        if (bus.start) begin
                            ctl.szero = 1'b1;
                            ctl.sen   = 1'b1;
                            act_d     = 1'b1;
                            ph_d      = PH_INIT;
                        end
                    end else if (ph_q != '0) begin
                        ph_d = ph_q - 1'b1;
                    end else begin
                        ctl.sen  = 1'b1;
                        ctl.sadd = 1'b1;
                        ctl.step = ENUM_S;
                        ctl.yen  = 1'b1;
                        ph_d     = PH_INIT;
                        if (bus.s_last) begin
                            act_d  = 1'b0;
                            rg_d   = R0;
                            done_d = 1'b1;
                        end
                    end
                end
                R2: begin
                    if (bus.start) begin
                        ctl.sen  = 1'b1;
                        ctl.step = DEC_S;
                        ctl.yen  = 1'b1;
                        ctl.ysel = 2'd1;
                    end else begin
                        rg_d = R0;
                    end
                end
                R3: begin
                    ph_d = ph_q - 1'b1;
                    case (upd_ph)
                        2'd3: begin
                            ctl.ysx = 1'b1;
                            ctl.yen = 1'b1;
                        end
                        2'd2: begin
                            ctl.yen  = 1'b1;
                            ctl.ysel = 2'd3;
                        end
                        2'd1: begin
                            ctl.sen  = 1'b1;
                            ctl.sadd = 1'b1;
                            ctl.step = UPD_S;
                        end
                        2'd0: begin
                            rg_d   = R0;
                            done_d = 1'b1;
                            ph_d   = PH_INIT;
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.regime        = rg_q;
    assign bus.active        = act_q;
    assign bus.done          = done_q;
    assign bus.phase         = ph_q;
    assign bus.y_select_next = ctl.ysel;
    assign bus.s_step        = ctl.step;
    assign bus.y_en          = ctl.yen;
    assign bus.s_en          = ctl.sen;
    assign bus.y_store_x     = ctl.ysx;
    assign bus.s_add         = ctl.sadd;
    assign bus.s_zero        = ctl.szero;
endmodule

// File: tb/tb_control_path_p.sv
// Bench for control_path_p: randomized regime scenarios expanded into expected
// per-cycle traces, played against a default instance and a 1-phase instance.
module tb_control_path_p;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_path_p_if #(.STEP_W(2), .PH_W(2)) ia ();
    control_path_p_if #(.STEP_W(2), .PH_W(2)) ib ();

    control_path_p dut_a (.clk(clk), .rst(rst), .bus(ia));
    control_path_p #(.STEP_W(2), .PH_W(2), .ENUM_PHASES(1), .ENUM_STEP(3),
                     .DEC_STEP(5), .UPD_STEP(1))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {ia.y_select_next, ia.s_step, ia.y_en, ia.s_en, ia.y_store_x, ia.s_add, ia.s_zero};
    assign ctl_b = {ib.y_select_next, ib.s_step, ib.y_en, ib.s_en, ib.y_store_x, ib.s_add, ib.s_zero};

    typedef struct {
        bit         tgt;
        logic [1:0] on;
        logic       start, abort, slast;
        logic [1:0] regime;
        logic       active, done;
        logic [1:0] phase;
        logic [8:0] ctl;
    } ent_t;

    ent_t q[$];
    bit   pdone;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom % 2);
    endfunction

    function automatic logic [1:0] ron();
        return 2'($urandom % 4);
    endfunction

    function automatic logic [8:0] mk(logic [1:0] ys, logic [1:0] st, logic yen, logic sen,
                                      logic ysx, logic sadd, logic sz);
        return {ys, st, yen, sen, ysx, sadd, sz};
    endfunction

    // done seen in a cycle is the completion flag of the previous cycle
    task automatic push(bit t, logic [1:0] on, logic st, logic ab, logic sl,
                        logic [1:0] rg, logic ac, int ph, logic [8:0] ctl, bit comp);
        ent_t e;
        e.tgt = t; e.on = on; e.start = st; e.abort = ab; e.slast = sl;
        e.regime = rg; e.active = ac; e.phase = 2'(ph); e.ctl = ctl;
        e.done = pdone;
        pdone = comp;
        q.push_back(e);
    endtask

    task automatic idle(bit t, int ep);
        push(t, 2'd0, rb(), 1'b0, rb(), 2'd0, 1'b0, ep - 1, 9'd0, 1'b0);
    endtask

    task automatic scen_enum(bit t, int ep, int es, int n, int d, int ab);
        int cyc = 0;
        idle(t, ep);
        push(t, 2'd1, rb(), 1'b0, rb(), 2'd0, 1'b0, ep - 1, 9'd0, 1'b0);
        for (int w = 0; w < d; w++) begin
            if (cyc == ab) begin push(t, ron(), 1'b0, 1'b1, rb(), 2'd1, 1'b0, ep - 1, 9'd0, 1'b0); return; end
            push(t, ron(), 1'b0, 1'b0, rb(), 2'd1, 1'b0, ep - 1, 9'd0, 1'b0);
            cyc++;
        end
        if (cyc == ab) begin push(t, ron(), 1'b1, 1'b1, rb(), 2'd1, 1'b0, ep - 1, 9'd0, 1'b0); return; end
        push(t, ron(), 1'b1, 1'b0, rb(), 2'd1, 1'b0, ep - 1, mk(2'd0, 2'd0, 0, 1, 0, 0, 1), 1'b0);
        cyc++;
        for (int i = 1; i <= n; i++) begin
            for (int ph = ep - 1; ph >= 0; ph--) begin
                bit last = (i == n) && (ph == 0);
                if (cyc == ab) begin
                    push(t, ron(), rb(), 1'b1, last ? 1'b1 : rb(), 2'd1, 1'b1, ph, 9'd0, 1'b0);
                    return;
                end
                if (ph > 0) push(t, ron(), rb(), 1'b0, rb(), 2'd1, 1'b1, ph, 9'd0, 1'b0);
                else        push(t, ron(), rb(), 1'b0, last, 2'd1, 1'b1, 0,
                                 mk(2'd0, 2'(es), 1, 1, 0, 1, 0), last);
                cyc++;
            end
        end
    endtask

    task automatic scen_man(bit t, int ep, int ds, int len, int ab);
        idle(t, ep);
        push(t, 2'd2, rb(), 1'b0, rb(), 2'd0, 1'b0, ep - 1, 9'd0, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (i == ab) begin push(t, ron(), 1'b1, 1'b1, rb(), 2'd2, 1'b0, ep - 1, 9'd0, 1'b0); return; end
            push(t, ron(), 1'b1, 1'b0, rb(), 2'd2, 1'b0, ep - 1, mk(2'd1, 2'(ds), 1, 1, 0, 0, 0), 1'b0);
        end
        push(t, ron(), 1'b0, logic'(ab == len), rb(), 2'd2, 1'b0, ep - 1, 9'd0, 1'b0);
    endtask

    task automatic scen_upd(bit t, int ep, int us, int ab);
        logic [8:0] seq [4];
        seq[3] = mk(2'd0, 2'd0, 1, 0, 1, 0, 0);
        seq[2] = mk(2'd3, 2'd0, 1, 0, 0, 0, 0);
        seq[1] = mk(2'd0, 2'(us), 0, 1, 0, 1, 0);
        seq[0] = 9'd0;
        idle(t, ep);
        push(t, 2'd3, rb(), 1'b0, rb(), 2'd0, 1'b0, ep - 1, 9'd0, 1'b0);
        for (int ph = 3; ph >= 0; ph--) begin
            if (ph == ab) begin push(t, ron(), rb(), 1'b1, rb(), 2'd3, 1'b0, ph, 9'd0, 1'b0); return; end
            push(t, ron(), rb(), 1'b0, rb(), 2'd3, 1'b0, ph, seq[ph], bit'(ph == 0));
        end
    endtask

    task automatic scen_r0abort(bit t, int ep);
        idle(t, ep);
        push(t, 2'($urandom_range(1, 3)), rb(), 1'b1, rb(), 2'd0, 1'b0, ep - 1, 9'd0, 1'b0);
    endtask

    task automatic scen_rand(bit t, int ep, int es, int ds, int us);
        int k = $urandom % 4;
        bit do_ab = ($urandom % 4) == 0;
        case (k)
            0: begin
                int n = $urandom_range(1, 3);
                int d = $urandom_range(0, 2);
                scen_enum(t, ep, es, n, d, do_ab ? $urandom_range(0, d + n * ep) : -1);
            end
            1: begin
                int len = $urandom_range(0, 6);
                scen_man(t, ep, ds, len, do_ab ? $urandom_range(0, len) : -1);
            end
            2: scen_upd(t, ep, us, do_ab ? $urandom_range(0, 3) : -1);
            default: scen_r0abort(t, ep);
        endcase
    endtask

    task automatic play();
        int idx = 0;
        while (q.size() > 0) begin
            ent_t e = q.pop_front();
            @(negedge clk);
            ia.on = 2'd0; ia.start = 1'b0; ia.abort = 1'b0; ia.s_last = 1'b0;
            ib.on = 2'd0; ib.start = 1'b0; ib.abort = 1'b0; ib.s_last = 1'b0;
            if (!e.tgt) begin
                ia.on = e.on; ia.start = e.start; ia.abort = e.abort; ia.s_last = e.slast;
            end else begin
                ib.on = e.on; ib.start = e.start; ib.abort = e.abort; ib.s_last = e.slast;
            end
            #1;
            if (!e.tgt) begin
                chk($sformatf("a%0d.regime", idx), 32'(ia.regime), 32'(e.regime));
                chk($sformatf("a%0d.active", idx), 32'(ia.active), 32'(e.active));
                chk($sformatf("a%0d.done", idx),   32'(ia.done),   32'(e.done));
                chk($sformatf("a%0d.phase", idx),  32'(ia.phase),  32'(e.phase));
                chk($sformatf("a%0d.ctl", idx),    32'(ctl_a),     32'(e.ctl));
            end else begin
                chk($sformatf("b%0d.regime", idx), 32'(ib.regime), 32'(e.regime));
                chk($sformatf("b%0d.active", idx), 32'(ib.active), 32'(e.active));
                chk($sformatf("b%0d.done", idx),   32'(ib.done),   32'(e.done));
                chk($sformatf("b%0d.phase", idx),  32'(ib.phase),  32'(e.phase));
                chk($sformatf("b%0d.ctl", idx),    32'(ctl_b),     32'(e.ctl));
            end
            idx++;
        end
    endtask

    initial begin
        ia.on = 2'd0; ia.start = 1'b0; ia.abort = 1'b0; ia.s_last = 1'b0;
        ib.on = 2'd0; ib.start = 1'b0; ib.abort = 1'b0; ib.s_last = 1'b0;
        pdone = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst.regime", 32'(ia.regime), 32'd0);
        chk("rst.active", 32'(ia.active), 32'd0);
        chk("rst.done",   32'(ia.done),   32'd0);
        chk("rst.phase",  32'(ia.phase),  32'd3);
        chk("rst.ctl",    32'(ctl_a),     32'd0);
        chk("rst.phase_b", 32'(ib.phase), 32'd0);
        rst = 1'b1;

        // default instance: plan scenarios first, then random mix
        scen_enum(1'b0, 4, 2, 3, 0, -1);
        scen_man(1'b0, 4, 1, 5, -1);
        scen_upd(1'b0, 4, 1, -1);
        scen_enum(1'b0, 4, 2, 2, 0, 2);
        scen_enum(1'b0, 4, 2, 2, 0, 0);
        scen_enum(1'b0, 4, 2, 1, 1, 5);
        scen_r0abort(1'b0, 4);
        for (int s = 0; s < 40; s++) scen_rand(1'b0, 4, 2, 1, 1);
        idle(1'b0, 4); idle(1'b0, 4);
        play();

        // asynchronous reset while manual step is driving enables
        @(negedge clk); ia.on = 2'd2;
        @(negedge clk); ia.on = 2'd0; ia.start = 1'b1; #1;
        chk("mid.regime", 32'(ia.regime), 32'd2);
        chk("mid.ctl",    32'(ctl_a), 32'(mk(2'd1, 2'd1, 1, 1, 0, 0, 0)));
        #1 rst = 1'b0; #1;
        chk("arst.regime", 32'(ia.regime), 32'd0);
        chk("arst.ctl",    32'(ctl_a), 32'd0);
        chk("arst.phase",  32'(ia.phase), 32'd3);
        @(negedge clk); rst = 1'b1; ia.start = 1'b0;
        pdone = 1'b0;

        // single-phase instance: write every active cycle, truncated dec step
        scen_enum(1'b1, 1, 3, 2, 0, -1);
        scen_man(1'b1, 1, 1, 3, -1);
        scen_upd(1'b1, 1, 1, -1);
        for (int s = 0; s < 20; s++) scen_rand(1'b1, 1, 3, 1, 1);
        idle(1'b1, 1); idle(1'b1, 1);
        play();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_path_p.md
Name: control_path_p

Overview:
- Parametrised successor of the four-regime machine controller: idle, enumerate, manual step, update.
- Drives the S/Y datapath enables, selects and step values from the `on` mode request, the `start` strobe and the `s_last` compare flag from the datapath.
- New over the previous generation: configurable step sizes and enumerate period, synchronous `abort`, a registered `done` pulse and an observable `phase` counter.

Parameters:
- STEP_W, 2, width of `s_step`.
- PH_W, 2, width of the phase counter.
- ENUM_PHASES, 4, cycles per enumerate iteration; legal range 1..2^PH_W.
- ENUM_STEP, 2, `s_step` value in enumerate.
- DEC_STEP, 1, `s_step` value in manual step.
- UPD_STEP, 1, `s_step` value in update.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- on  in  2  mode request, sampled only in R0.
- start  in  1  launch in R1; hold-to-run in R2.
- abort  in  1  synchronous cancel of any regime.
- s_last  in  1  datapath flag: S has reached its final value.
- regime  out  2  current regime: R0=0, R1=1, R2=2, R3=3; registered.
- active  out  1  enumerate in progress; registered.
- done  out  1  one-cycle completion pulse; registered.
- phase  out  PH_W  current phase counter; registered.
- y_select_next  out  2  Y next-value source select.
- s_step  out  STEP_W  step applied to S.
- y_en  out  1  Y register write enable.
- s_en  out  1  S register write enable.
- y_store_x  out  1  load X into Y.
- s_add  out  1  1 = S+step, 0 = S−step.
- s_zero  out  1  clear S.

Behaviour:
- Reset (rst=0, asynchronous): regime=R0, active=0, done=0, phase=ENUM_PHASES-1.
- All unregistered control outputs are combinational from (regime, active, phase, start, s_last). Default value of each is 0.
- `done` defaults to 0 every cycle. It is 1 only in the cycle after a completing edge (R1 finish or R3 finish). It is never set by abort or by R2 exit.
- R0: next regime = `on`. All control outputs are 0. `phase` is held at ENUM_PHASES-1.
- R1, active=0:
  - start=1 → s_zero=1 and s_en=1 this cycle; active←1; phase←ENUM_PHASES-1.
  - start=0 → wait; no outputs.
- R1, active=1, phase≠0: phase←phase-1; no enables.
- R1, active=1, phase==0:
  - s_en=1, s_add=1, s_step=ENUM_STEP, y_en=1, y_select_next=0; phase←ENUM_PHASES-1.
  - If s_last=1 in the same cycle: the final write still occurs; active←0, regime←R0, done←1.
- R1 with ENUM_PHASES=1: phase stays 0, so an update happens every cycle.
- R2, start=1: every cycle s_en=1, s_add=0, s_step=DEC_STEP, y_en=1, y_select_next=1.
- R2, start=0: no outputs; regime←R0.
- R3 runs fixed phases counting down from 3, using the low 2 bits of `phase` loaded with 3 on entry:
  - phase 3: y_store_x=1, y_en=1.
  - phase 2: y_en=1, y_select_next=3.
  - phase 1: s_en=1, s_add=1, s_step=UPD_STEP.
  - phase 0: no enables; regime←R0, done←1, phase←ENUM_PHASES-1.
- Requirement: PH_W≥2 when R3 is used.
- Entry from R0: phase←ENUM_PHASES-1 when entering R1; phase←3 when entering R3.
- abort=1 in any regime: all control outputs forced to 0 that cycle; regime←R0, active←0, phase←ENUM_PHASES-1, done stays 0. Abort has priority over s_last and over phase 0.
- Simultaneous abort and start in R1 idle: abort wins; s_zero=0.
- `on` changes outside R0 are ignored.
- Reset mid-regime: immediate return to reset values; outputs drop to 0 asynchronously.
- Step values are truncated to STEP_W bits.

Test Plan:
- rst low 2 cycles, then high with on=0 → regime=0, active=0, done=0, phase=3, all enables 0.
- on=1, then start=1 for 1 cycle, s_last asserted at the 3rd phase-0 cycle (defaults) → s_zero=1 in the start cycle; s_en/y_en/s_add=1 with s_step=2 every 4th cycle, 3 times; regime=0 and done=1 for exactly 1 cycle after the third write.
- on=2 with start=1 for 5 cycles, then 0 → s_en=y_en=1, s_add=0, s_step=1, y_select_next=1 for 5 cycles; regime=0 the cycle after start falls; done never asserted.
- on=3 → 4-cycle sequence: y_store_x/y_en; y_en with y_select_next=3; s_en/s_add with s_step=1; idle; then regime=0 and done=1 for one cycle.
- R1 active at phase=2, abort=1 for 1 cycle → regime=0, active=0, no s_en, done=0.
- Parameters ENUM_PHASES=1, ENUM_STEP=3, STEP_W=2; R1 running, s_last asserted in cycle 2 → s_en=1 with s_step=3 in both cycles 1 and 2, then exit to R0 with done=1.
